rtc_multi_divider: RTL
======================

RTC_MULTI_DIVIDER -- requirements
Module: rtc_multi_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 24: width of each half-period counter and divisor.
REQ-003 SHALL have parameter DEF_HALF, default {24'd2500000, 24'd1000}: flattened NUM_CH*CNT_W reset half-periods, channel 0 in the LSBs. With a 1 MHz sys_clk this gives ch0 = 500 Hz and ch1 = 0.2 Hz.
REQ-004 SHALL have port sys_clk, input, 1: the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port ch_en, input, NUM_CH: per-channel run enable.
REQ-007 SHALL have port resync, input, 1: single-cycle pulse that phase-aligns all channels.
REQ-008 SHALL have port wr_en, input, 1: divisor write strobe.
REQ-009 SHALL have port wr_ch, input, 3: target channel index for a divisor write.
REQ-010 SHALL have port wr_half, input, CNT_W: new half-period value, in sys_clk cycles.
REQ-011 SHALL have port clk_out, output, NUM_CH: registered square wave per channel.
REQ-012 SHALL have port tick, output, NUM_CH: registered one-cycle pulse marking each 0->1 transition of clk_out.

Function
REQ-013 Each channel SHALL hold three registers:
- shadow half (half_sh)
- active half (half_act)
- counter (cnt)
REQ-014 A running channel SHALL have ch_en=1 and half_act!=0; otherwise the channel is stopped.
REQ-015 A running channel SHALL, on each edge:
- if cnt == half_act-1: toggle clk_out, clear cnt, and load half_act <= half_sh;
- otherwise: increment cnt.
REQ-016 Output period SHALL be 2*half_act cycles at 50% duty. half_act=1 SHALL give clk_out = sys_clk/2.
REQ-017 tick[ch] SHALL be 1 for exactly the cycle on which clk_out[ch] is first high (same edge as the 0->1 toggle); otherwise 0.
REQ-018 A write (wr_en=1, wr_ch<NUM_CH) SHALL update half_sh[wr_ch] on that edge.
- The new value SHALL take effect at the next toggle of that channel, so no shortened or runt half-period occurs.
- Writes with wr_ch>=NUM_CH SHALL be ignored.
REQ-019 A stopped channel SHALL, on each edge:
- hold cnt=0, clk_out=0 and tick=0;
- load half_act <= half_sh, including a half_sh value written on that same edge.
REQ-020 On re-enable, a channel SHALL behave as after reset: first clk_out rise on the half_act-th edge with ch_en=1.
REQ-021 resync=1 SHALL, on that edge, for all channels:
- clear cnt and clk_out and force tick=0;
- load half_act <= half_sh, where a simultaneous write is applied first and its value is loaded.
REQ-022 resync SHALL take priority over counting. Subsequent behaviour SHALL follow REQ-020 so that all channels with equal half_act toggle in phase.
REQ-023 Writing half_sh=0 SHALL stop the channel at its next toggle, with clk_out held at 0 thereafter.
REQ-024 cnt SHALL never exceed half_act-1. No wrap-around beyond CNT_W SHALL occur for any half value from 1 to 2^CNT_W-1.
REQ-025 Channels SHALL be fully independent; ch_en, writes and counting on one channel SHALL not affect another, except for resync and rst_n.
REQ-026 Outputs SHALL be driven directly from registers, with no combinational path from any input to clk_out or tick.

Reset
REQ-027 On an edge with rst_n=0, every channel SHALL be set to cnt=0, clk_out=0, tick=0 and half_sh=half_act=DEF_HALF slice.
REQ-028 rst_n=0 SHALL override resync, wr_en and ch_en.
REQ-029 rst_n=0 mid-period SHALL abort the period without a tick.
REQ-030 After rst_n rises, with ch_en=1, the first clk_out rise SHALL occur on the DEF_HALF-th edge.

Verification
REQ-031 Reset with NUM_CH=2 and DEF_HALF={3,2}, then ch_en=11 -> ch0 clk_out rises on edges 2, 6, 10 with tick on the same edges; ch1 rises on edges 3, 9.
REQ-032 ch0 half=2 running; write wr_ch=0, wr_half=5 at cnt=0 of a high phase -> current high phase still lasts 2 cycles, then low 5, high 5.
REQ-033 ch0 half=4, ch1 half=4 but offset by 2 cycles; pulse resync -> both rise on the 4th edge after resync and stay in phase.
REQ-034 Write wr_half=0 to ch1 while running -> clk_out[1] falls or stays low at the next toggle and never rises again; a later write of 3 with ch_en=1 -> first rise 3 edges after that write.
REQ-035 Deassert ch_en[0] mid high phase -> clk_out[0]=0 and tick[0]=0 on the next edge; re-assert -> rise after half_act edges.
REQ-036 Assert rst_n=0 for 1 cycle mid-period, with a simultaneous write and resync -> all registers equal reset values and the write is lost.
REQ-037 Write with wr_ch=5 (NUM_CH=2) -> no change to any channel.

Source files
------------

// File: rtl/rtc_multi_divider.sv
// rtl/rtc_multi_divider.sv - multi-channel programmable square-wave divider with shadowed divisors
// Each channel counts half-periods of sys_clk; divisor updates are deferred to the next toggle.
module rtc_multi_divider #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {24'd2500000, 24'd1000}
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              resync,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] half_sh  [NUM_CH];
  logic [CNT_W-1:0] half_act [NUM_CH];
  logic [CNT_W-1:0] cnt      [NUM_CH];
  logic [CNT_W-1:0] sh_next  [NUM_CH];
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] at_end;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sh_next[ch] = half_sh[ch];
      if (wr_en && (wr_ch == 3'(ch)))
        sh_next[ch] = wr_half;
      running[ch] = ch_en[ch] && (half_act[ch] != '0);
      at_end[ch]  = (cnt[ch] == (half_act[ch] - ONE));
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!rst_n) begin
        half_sh[ch]  <= DEF_HALF[ch*CNT_W +: CNT_W];
        half_act[ch] <= DEF_HALF[ch*CNT_W +: CNT_W];
        cnt[ch]      <= '0;
        clk_out[ch]  <= 1'b0;
        tick[ch]     <= 1'b0;
      end else begin
        half_sh[ch] <= sh_next[ch];
        if (resync || !running[ch]) begin
          // Stopped or resynced channels track the shadow so a restart uses the newest divisor.
          half_act[ch] <= sh_next[ch];
          cnt[ch]      <= '0;
          clk_out[ch]  <= 1'b0;
          tick[ch]     <= 1'b0;
        end else if (at_end[ch]) begin
          cnt[ch]      <= '0;
          half_act[ch] <= half_sh[ch];
          // A zero divisor parks the output low instead of producing a final rise.
          if (half_sh[ch] == '0) begin
            clk_out[ch] <= 1'b0;
            tick[ch]    <= 1'b0;
          end else begin
            clk_out[ch] <= ~clk_out[ch];
            tick[ch]    <= ~clk_out[ch];
          end
        end else begin
          cnt[ch]  <= cnt[ch] + ONE;
          tick[ch] <= 1'b0;
        end
      end
    end
  end

endmodule
